// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_wr_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  // Index width that never collapses to zero for a single requester.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-side bundle for the arbiter
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  import fifo_wr_arb_pkg::*;

  localparam int IDW = clog2_min1(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  awfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IDW-1:0]        gnt_id;
  logic                  busy;

  // Requesters plus FIFO flags side.
  modport master (
    output req_valid, req_last, req_data, wfull, awfull,
    input  req_ready, winc, wdata, gnt_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_last, req_data, wfull, awfull,
    output req_ready, winc, wdata, gnt_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                off;
  int                pos;

  // Rotate the doubled request vector so bit 0 is the requester just after ptr,
  // then take the lowest set bit and map it back to an absolute index.
  always_comb begin
    dbl = {req, req};
    rot = NREQ'(dbl >> (int'(ptr) + 1));
    any = 1'b0;
    off = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        off = i;
      end
    end
    pos = int'(ptr) + 1 + off;
    if (pos >= NREQ) pos = pos - NREQ;
    idx = IDW'(pos);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, packet-locked arbiter for the async FIFO write port
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
) (
  input  logic              wclk,
  input  logic              wrst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IDW = clog2_min1(NREQ);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             winc_q, winc_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic             busy_q, busy_d;

  logic             can_accept;
  logic             pick_any;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   sel;
  logic [NREQ-1:0]  ready;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Grant selection, FIFO-space check and next-state for the FSM and output stage.
  always_comb begin
    // The write still in flight would consume the last free slot.
    can_accept = !bus.wfull && !(winc_q && bus.awfull);
    ready      = '0;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    winc_d     = 1'b0;
    sel        = (state_q == ARB_IDLE) ? pick_idx : gnt_id_q;

    if (state_q == ARB_IDLE) begin
      if (pick_any && can_accept) ready[pick_idx] = 1'b1;
    end else begin
      if (bus.req_valid[gnt_id_q] && can_accept) ready[gnt_id_q] = 1'b1;
    end
    if (wrst) ready = '0;

    if (|ready) begin
      winc_d   = 1'b1;
      wdata_d  = bus.req_data[int'(sel)*DSIZE +: DSIZE];
      gnt_id_d = sel;
      if (state_q == ARB_IDLE) begin
        if (!bus.req_last[sel]) begin
          state_d = ARB_LOCK;
          busy_d  = 1'b1;
        end else begin
          rr_ptr_d = sel;
        end
      end else if (bus.req_last[sel]) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = gnt_id_q;
        busy_d   = 1'b0;
      end
    end
  end

  // State and registered outputs; reset abandons any packet in progress.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= IDW'(NREQ - 1);
      gnt_id_q <= '0;
      winc_q   <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
      winc_q   <= winc_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.winc      = winc_q;
  assign bus.wdata     = wdata_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  import fifo_wr_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]      rq[NREQ][$];
  logic [NREQ-1:0] hold = '0;
  logic [7:0]      sb[$];
  int              winc_log[$];
  int              fcount = 0;
  int              overflow = 0;
  logic            drain = 1'b1;
  int              cyc = 0;
  int              busy_cnt = 0;
  logic [NREQ-1:0] last_rdy;
  logic            last_winc;
  logic [1:0]      last_gnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic apply();
    logic [NREQ-1:0]       v, l;
    logic [NREQ*DSIZE-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0 && !hold[i]) begin
        v[i] = 1'b1;
        l[i] = rq[i][0][8];
        d[i*DSIZE +: DSIZE] = rq[i][0][7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.wfull     = (fcount >= 16);
    bus.awfull    = (fcount == 15);
  endtask

  task automatic step();
    @(negedge wclk);
    cyc++;
    last_rdy  = bus.req_ready;
    last_winc = bus.winc;
    check_eq("ready_onehot0", 32'($onehot0(last_rdy)), 32'd1);
    if (bus.busy) busy_cnt++;
    if (last_winc) begin
      last_gnt = bus.gnt_id;
      winc_log.push_back(cyc);
      if (sb.size() == 0) check_eq("winc_without_expect", 32'(bus.wdata), 32'hFFFF_FFFF);
      else check_eq("wdata", 32'(bus.wdata), 32'(sb.pop_front()));
    end
    @(posedge wclk);
    #1;
    if (drain) fcount = 0;
    else if (last_winc) begin
      if (fcount >= 16) overflow++;
      else fcount++;
    end
    if (!wrst) begin
      for (int i = 0; i < NREQ; i++)
        if (last_rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    apply();
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int b;
    b = budget;
    while (sb.size() > 0 && b > 0) begin
      step();
      b--;
    end
    check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_qsize(input string tag, input int r, input int sz, input int budget);
    int b;
    b = budget;
    while (rq[r].size() != sz && b > 0) begin
      step();
      b--;
    end
    check_eq({tag, "_accept_seen"}, 32'(rq[r].size()), 32'(sz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Test 1/2: all requesters valid through reset, 1-beat packets A0..A3 x3
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NREQ; i++) begin
        rq[i].push_back({1'b1, 8'(8'hA0 + i)});
        sb.push_back(8'(8'hA0 + i));
      end
    apply();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_winc", 32'(bus.winc), 32'd0);
    check_eq("rst_wdata", 32'(bus.wdata), 32'd0);
    check_eq("rst_gnt", 32'(bus.gnt_id), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    apply();
    winc_log.delete();
    step();
    check_eq("t1_first_ready", 32'(last_rdy), 32'b0001);
    check_eq("t1_no_winc_yet", 32'(last_winc), 32'd0);
    step();
    check_eq("t1_first_winc", 32'(last_winc), 32'd1);
    check_eq("t1_first_gnt", 32'(last_gnt), 32'd0);
    run_until_empty("t2", 40);
    check_eq("t2_beats", 32'(winc_log.size()), 32'd12);
    if (winc_log.size() == 12)
      check_eq("t2_throughput", 32'(winc_log[11] - winc_log[0]), 32'd11);

    // Test 3: req1 3-beat packet while req2 stays valid
    repeat (2) step();
    busy_cnt = 0;
    rq[1].push_back({1'b0, 8'h11});
    rq[1].push_back({1'b0, 8'h12});
    rq[1].push_back({1'b1, 8'h13});
    rq[2].push_back({1'b1, 8'h21});
    rq[2].push_back({1'b1, 8'h22});
    sb.push_back(8'h11); sb.push_back(8'h12); sb.push_back(8'h13);
    sb.push_back(8'h21); sb.push_back(8'h22);
    apply();
    run_until_empty("t3", 40);
    check_eq("t3_busy_cycles", 32'(busy_cnt), 32'd2);
    check_eq("t3_last_gnt", 32'(last_gnt), 32'd2);

    // Test 4: owner req1 drops valid for 2 cycles mid-packet, req3 waiting
    repeat (2) step();
    hold[3] = 1'b1;
    rq[1].push_back({1'b0, 8'h31});
    rq[1].push_back({1'b0, 8'h32});
    rq[1].push_back({1'b1, 8'h33});
    rq[3].push_back({1'b1, 8'h3F});
    sb.push_back(8'h31); sb.push_back(8'h32); sb.push_back(8'h33); sb.push_back(8'h3F);
    apply();
    wait_qsize("t4", 1, 2, 10);
    hold[1] = 1'b1;
    hold[3] = 1'b0;
    apply();
    step();
    check_eq("t4_bubble_rdy0", 32'(last_rdy), 32'd0);
    step();
    check_eq("t4_bubble_rdy1", 32'(last_rdy), 32'd0);
    check_eq("t4_bubble_winc0", 32'(last_winc), 32'd0);
    hold[1] = 1'b0;
    apply();
    winc_log.delete();
    step();
    check_eq("t4_bubble_winc1", 32'(last_winc), 32'd0);
    check_eq("t4_resume_rdy", 32'(last_rdy), 32'b0010);
    run_until_empty("t4", 20);
    check_eq("t4_beats", 32'(winc_log.size()), 32'd3);
    if (winc_log.size() == 3)
      check_eq("t4_contiguous", 32'(winc_log[1] - winc_log[0]), 32'd1);

    // Test 5: FIFO prefilled to 15, req0 streams; exactly one more write
    repeat (2) step();
    drain = 1'b0;
    fcount = 15;
    overflow = 0;
    for (int k = 0; k < 4; k++) rq[0].push_back({1'b1, 8'(8'h50 + k)});
    sb.push_back(8'h50);
    apply();
    winc_log.delete();
    repeat (10) step();
    check_eq("t5_one_write", 32'(winc_log.size()), 32'd1);
    check_eq("t5_fcount", 32'(fcount), 32'd16);
    check_eq("t5_overflow", 32'(overflow), 32'd0);
    check_eq("t5_left", 32'(rq[0].size()), 32'd3);
    check_eq("t5_full_rdy", 32'(last_rdy), 32'd0);
    check_eq("t5_full_winc", 32'(last_winc), 32'd0);
    drain = 1'b1;
    for (int k = 1; k < 4; k++) sb.push_back(8'(8'h50 + k));
    run_until_empty("t5", 20);

    // Test 6: reset in the middle of a req2 3-beat packet
    repeat (2) step();
    rq[2].push_back({1'b0, 8'h61});
    rq[2].push_back({1'b0, 8'h62});
    rq[2].push_back({1'b1, 8'h63});
    sb.push_back(8'h61);
    apply();
    wait_qsize("t6", 2, 2, 10);
    step();
    check_eq("t6_pre_busy", 32'(bus.busy), 32'd1);
    check_eq("t6_pre_winc", 32'(bus.winc), 32'd1);
    wrst = 1'b1;
    #1;
    check_eq("t6_rst_winc", 32'(bus.winc), 32'd0);
    check_eq("t6_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("t6_rst_gnt", 32'(bus.gnt_id), 32'd0);
    check_eq("t6_rst_ready", 32'(bus.req_ready), 32'd0);
    rq[2].delete();
    hold = '0;
    rq[0].push_back({1'b1, 8'h70});
    rq[3].push_back({1'b1, 8'h73});
    apply();
    repeat (2) step();
    wrst = 1'b0;
    sb.push_back(8'h70);
    sb.push_back(8'h73);
    apply();
    step();
    check_eq("t6_first_ready", 32'(last_rdy), 32'b0001);
    run_until_empty("t6", 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
